// File: rtl/fir_sched_if.sv
// fir_sched_if: every non-clock signal of the FIR scheduler. master = register decode / datapath side,
// slave = the scheduler.
interface fir_sched_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    logic                   cfg_start;
    logic [pDATA_WIDTH-1:0] cfg_len;
    logic                   cfg_stat_rd;
    logic                   cfg_tap_req;
    logic                   cfg_tap_wr;
    logic [3:0]             cfg_tap_idx;
    logic                   cfg_tap_gnt;
    logic                   ss_tvalid;
    logic                   ss_tlast;
    logic                   ss_tready;
    logic                   sm_tready;
    logic                   sm_tvalid;
    logic                   sm_tlast;
    logic                   tap_EN;
    logic [3:0]             tap_WE;
    logic [pADDR_WIDTH-1:0] tap_A;
    logic                   data_EN;
    logic [3:0]             data_WE;
    logic [pADDR_WIDTH-1:0] data_A;
    logic                   data_sel_zero;
    logic                   mac_clr;
    logic                   mac_en;
    logic                   ap_start;
    logic                   ap_done;
    logic                   ap_idle;
    logic                   err_tlast;
    logic [pDATA_WIDTH-1:0] perf_cycles;

    modport master (
        output cfg_start, cfg_len, cfg_stat_rd, cfg_tap_req, cfg_tap_wr, cfg_tap_idx,
               ss_tvalid, ss_tlast, sm_tready,
        input  cfg_tap_gnt, ss_tready, sm_tvalid, sm_tlast, tap_EN, tap_WE, tap_A,
               data_EN, data_WE, data_A, data_sel_zero, mac_clr, mac_en,
               ap_start, ap_done, ap_idle, err_tlast, perf_cycles
    );

    modport slave (
        input  cfg_start, cfg_len, cfg_stat_rd, cfg_tap_req, cfg_tap_wr, cfg_tap_idx,
               ss_tvalid, ss_tlast, sm_tready,
        output cfg_tap_gnt, ss_tready, sm_tvalid, sm_tlast, tap_EN, tap_WE, tap_A,
               data_EN, data_WE, data_A, data_sel_zero, mac_clr, mac_en,
               ap_start, ap_done, ap_idle, err_tlast, perf_cycles
    );
endinterface

// File: rtl/fir_sched.sv
// fir_sched: ap_start/done/idle sequencer, tap-RAM arbiter and circular data-RAM addressing for the FIR.
// Defining FIR_SCHED_PERF_CNT_EN builds the saturating busy-cycle counter on perf_cycles.
module fir_sched #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic       axis_clk,
    input  logic       axis_rst,
    fir_sched_if.slave bus
);
    localparam logic [3:0] LAST_K  = 4'(Tape_Num - 1);
    localparam logic [3:0] DRAIN_K = 4'(Tape_Num);

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_MAC, S_OUT, S_DONE} state_t;

    state_t                 state, state_nxt;
    logic [3:0]             k, wptr, didx;
    logic [pDATA_WIDTH-1:0] cnt, len_q;
    logic                   start_q, done_q, err_q;
    logic                   idle_like, start_acc, ss_hs, sm_hs, last_out, tlast_exp;

    function automatic logic [pADDR_WIDTH-1:0] waddr(input logic [3:0] w);
        return {{(pADDR_WIDTH-6){1'b0}}, w, 2'b00};
    endfunction

    assign idle_like = (state == S_IDLE) || (state == S_DONE);
    assign start_acc = (state == S_IDLE) && bus.cfg_start;
    assign ss_hs     = (state == S_WAIT) && bus.ss_tvalid;
    assign sm_hs     = (state == S_OUT) && bus.sm_tready;
    // cnt already counts the sample in flight once we are past WAIT
    assign last_out  = (cnt == len_q);
    assign tlast_exp = ((cnt + pDATA_WIDTH'(1)) == len_q);
    // newest sample sits at wptr; tap k pairs with the sample k positions older
    assign didx      = (wptr >= k) ? (wptr - k) : (wptr + DRAIN_K - k);

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.cfg_start) state_nxt = S_INIT;
            S_INIT:  if (k == LAST_K) state_nxt = (len_q == '0) ? S_DONE : S_WAIT;
            S_WAIT:  if (bus.ss_tvalid) state_nxt = S_MAC;
            S_MAC:   if (k == DRAIN_K) state_nxt = S_OUT;
            S_OUT:   if (bus.sm_tready) state_nxt = last_out ? S_DONE : S_WAIT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            k       <= '0;
            wptr    <= '0;
            cnt     <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_nxt != state)                      k <= '0;
            else if (state == S_INIT || state == S_MAC)  k <= k + 4'd1;

            if (start_acc) begin
                len_q   <= bus.cfg_len;
                cnt     <= '0;
                wptr    <= '0;
                start_q <= 1'b1;
                err_q   <= 1'b0;
            end
            if (ss_hs) begin
                cnt     <= cnt + pDATA_WIDTH'(1);
                start_q <= 1'b0;
                if (bus.ss_tlast != tlast_exp) err_q <= 1'b1;
            end
            if (sm_hs) wptr <= (wptr == LAST_K) ? 4'd0 : wptr + 4'd1;
            // a zero-length run never sees a sample, so ap_start drops on completion
            if (state_nxt == S_DONE) start_q <= 1'b0;

            if (start_acc)                                  done_q <= 1'b0;
            else if (state_nxt == S_DONE)                   done_q <= 1'b1;
            else if (state == S_IDLE && bus.cfg_stat_rd)    done_q <= 1'b0;
        end
    end

    always_comb begin
        bus.cfg_tap_gnt   = 1'b0;
        bus.ss_tready     = 1'b0;
        bus.sm_tvalid     = 1'b0;
        bus.sm_tlast      = 1'b0;
        bus.tap_EN        = 1'b0;
        bus.tap_WE        = 4'h0;
        bus.tap_A         = '0;
        bus.data_EN       = 1'b0;
        bus.data_WE       = 4'h0;
        bus.data_A        = '0;
        bus.data_sel_zero = 1'b0;
        bus.mac_clr       = 1'b0;
        bus.mac_en        = 1'b0;
        bus.ap_start      = start_q;
        bus.ap_done       = done_q;
        bus.ap_idle       = idle_like;
        bus.err_tlast     = err_q;
        case (state)
            S_IDLE, S_DONE: begin
                bus.cfg_tap_gnt = bus.cfg_tap_req;
                bus.tap_EN      = bus.cfg_tap_req;
                bus.tap_WE      = (bus.cfg_tap_req && bus.cfg_tap_wr) ? 4'hF : 4'h0;
                bus.tap_A       = bus.cfg_tap_req ? waddr(bus.cfg_tap_idx) : '0;
            end
            S_INIT: begin
                bus.data_EN       = 1'b1;
                bus.data_WE       = 4'hF;
                bus.data_A        = waddr(k);
                bus.data_sel_zero = 1'b1;
            end
            S_WAIT: begin
                bus.ss_tready = 1'b1;
                bus.data_EN   = bus.ss_tvalid;
                bus.data_WE   = bus.ss_tvalid ? 4'hF : 4'h0;
                bus.data_A    = waddr(wptr);
                bus.mac_clr   = bus.ss_tvalid;
            end
            S_MAC: begin
                // k == DRAIN_K only accumulates the last read; no RAM access
                if (k <= LAST_K) begin
                    bus.tap_EN  = 1'b1;
                    bus.tap_A   = waddr(k);
                    bus.data_EN = 1'b1;
                    bus.data_A  = waddr(didx);
                end
                bus.mac_en = (k != 4'd0);
            end
            S_OUT: begin
                bus.sm_tvalid = 1'b1;
                bus.sm_tlast  = last_out;
            end
            default: ;
        endcase
    end

`ifdef FIR_SCHED_PERF_CNT_EN
    logic [pDATA_WIDTH-1:0] perf_q;
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst)                          perf_q <= '0;
        else if (start_acc)                    perf_q <= '0;
        else if (!idle_like && perf_q != '1)   perf_q <= perf_q + pDATA_WIDTH'(1);
    end
    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif
endmodule

// File: tb/tb_fir_sched.sv
// tb_fir_sched: drives fir_sched with behavioural tap/data RAMs and a MAC, and compares every output
// sample against a direct convolution of the stimulus with the tap set.
module tb_fir_sched;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NT = 11;

    logic axis_clk = 1'b0;
    logic axis_rst;
    always #5 axis_clk = ~axis_clk;

    fir_sched_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus();
    fir_sched #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT)) dut (
        .axis_clk (axis_clk),
        .axis_rst (axis_rst),
        .bus      (bus)
    );

    int total = 0;
    int bad   = 0;
    int taps[NT] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

    // environment: single-port RAMs with 1-cycle read latency plus the accumulator
    int tap_ram[NT];
    int data_ram[NT];
    int tap_do, data_do, acc, tap_wdata, ss_tdata;
    always @(posedge axis_clk) begin
        if (bus.tap_EN) begin
            if (bus.tap_WE == 4'hF) tap_ram[int'(bus.tap_A[AW-1:2])] <= tap_wdata;
            tap_do <= tap_ram[int'(bus.tap_A[AW-1:2])];
        end
        if (bus.data_EN) begin
            if (bus.data_WE == 4'hF) data_ram[int'(bus.data_A[AW-1:2])] <= bus.data_sel_zero ? 0 : ss_tdata;
            data_do <= data_ram[int'(bus.data_A[AW-1:2])];
        end
        if (bus.mac_clr)     acc <= 0;
        else if (bus.mac_en) acc <= acc + tap_do * data_do;
    end

    typedef struct {
        bit         wr;
        logic [3:0] idx;
        int         wdat;
        logic [3:0] we;
        logic [11:0] a;
        int         rd;
    } tap_vec_t;
    tap_vec_t tv[2*NT];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    function automatic int active_bits();
        return $countones({bus.cfg_tap_gnt, bus.ss_tready, bus.sm_tvalid, bus.sm_tlast, bus.tap_EN,
                           bus.tap_WE, bus.tap_A, bus.data_EN, bus.data_WE, bus.data_A, bus.data_sel_zero,
                           bus.mac_clr, bus.mac_en, bus.ap_start, bus.ap_done, bus.err_tlast, bus.perf_cycles});
    endfunction

    function automatic int yref(input int xs[$], input int n);
        int s = 0;
        for (int j = 0; j < NT; j++)
            if (n - j >= 0) s += taps[j] * xs[n - j];
        return s;
    endfunction

    // one complete job; called and returns at posedge+1 with the DUT idle
    task automatic run(input int len, input int tl_at, input bit rnd, input bit bp, input bit treq, input bit sr);
        int  xs[$];
        int  sent = 0, got = 0, cyc = 0, hs_cyc = 0, hs11 = -100, stall = 0, viol = 0, gnt_bad = 0;
        bit  exp_err = 0, prev_v = 0, prev_hs = 0, done_seen = 0, tl;
        for (int n = 0; n < len; n++) begin
            xs.push_back(rnd ? int'($urandom_range(0, 2000)) - 1000 : ((n % 64 < 32) ? n % 64 : 64 - n % 64));
            tl = (tl_at < 0) ? (n == len - 1) : (n == tl_at);
            if (tl != (n == len - 1)) exp_err = 1;
        end
        bus.cfg_start = 1; bus.cfg_stat_rd = sr; bus.cfg_len = DW'(len);
        bus.cfg_tap_req = treq; bus.cfg_tap_wr = 0; bus.cfg_tap_idx = 0;
        tick();
        bus.cfg_start = 0; bus.cfg_stat_rd = 0; bus.cfg_len = DW'(len + 3);
        #3;
        check("start_ap_start", bus.ap_start, 1);
        check("start_ap_done", bus.ap_done, 0);
        check("start_ap_idle", bus.ap_idle, 0);
        check("start_err_clr", bus.err_tlast, 0);
        while (!done_seen && cyc < 20 * len + 100) begin
            bus.ss_tvalid = (sent < len) && (!rnd || $urandom_range(0, 3) != 0);
            ss_tdata      = (sent < len) ? xs[sent] : 0;
            bus.ss_tlast  = (tl_at < 0) ? (sent == len - 1) : (sent == tl_at);
            bus.sm_tready = !(rnd && $urandom_range(0, 2) == 0) && !(bp && got == 0 && stall < 5);
            bus.cfg_start = (cyc == 20);
            #3;
            if (bus.sm_tvalid && bus.ss_tready) viol++;
            if (prev_v && !prev_hs && !bus.sm_tvalid) viol++;
            if (sent >= len && bus.ss_tready) viol++;
            if (treq && !bus.ap_idle && bus.cfg_tap_gnt) gnt_bad++;
            if (cyc == hs11 + 4) begin
                check("mac_k3_data_A", bus.data_A, 4 * ((11 - 3) % NT));
                check("mac_k3_tap_A", bus.tap_A, 4 * 3);
            end
            if (bus.sm_tvalid && !prev_v) check("latency", cyc - hs_cyc, NT + 2);
            if (bus.sm_tvalid && bus.sm_tready) begin
                check("y", acc, yref(xs, got));
                check("sm_tlast", bus.sm_tlast, got == len - 1);
                got++;
            end else if (bus.sm_tvalid) stall++;
            if (bus.ss_tvalid && bus.ss_tready) begin
                hs_cyc = cyc;
                if (sent == 11) hs11 = cyc;
                sent++;
            end
            prev_v  = bus.sm_tvalid;
            prev_hs = bus.sm_tvalid && bus.sm_tready;
            if (bus.ap_done) begin
                done_seen = 1;
                check("done_idle", bus.ap_idle, 1);
                check("err_tlast", bus.err_tlast, exp_err);
            end
            cyc++;
            tick();
        end
        bus.cfg_start = 0; bus.ss_tvalid = 0; bus.ss_tlast = 0; bus.cfg_tap_req = 0;
        if (!done_seen) check("run_timeout", 0, 1);
        check("out_count", got, len);
        check("protocol", viol, 0);
        if (treq) check("busy_tap_gnt", gnt_bad, 0);
        if (bp) check("bp_stall", stall, 5);
        #3;
        check("done_held", bus.ap_done, 1);
        check("idle_after", bus.ap_idle, 1);
        #(-0);
    endtask

    initial begin
        bus.cfg_start = 0; bus.cfg_len = 0; bus.cfg_stat_rd = 0; bus.cfg_tap_req = 0;
        bus.cfg_tap_wr = 0; bus.cfg_tap_idx = 0; bus.ss_tvalid = 0; bus.ss_tlast = 0; bus.sm_tready = 0;
        tap_wdata = 0; ss_tdata = 0;
        axis_rst = 0;
        #1 axis_rst = 1;
        #1;
        check("rst_outputs", active_bits(), 0);
        check("rst_idle", bus.ap_idle, 1);
        repeat (2) @(posedge axis_clk);
        #3 axis_rst = 0;
        tick();

        // tap programming and readback from the vector table
        for (int i = 0; i < NT; i++) begin
            tv[i]      = '{1'b1, 4'(i), taps[i], 4'hF, 12'(4 * i), 0};
            tv[NT + i] = '{1'b0, 4'(i), 0, 4'h0, 12'(4 * i), taps[i]};
        end
        for (int i = 0; i < 2 * NT; i++) begin
            bus.cfg_tap_req = 1; bus.cfg_tap_wr = tv[i].wr; bus.cfg_tap_idx = tv[i].idx; tap_wdata = tv[i].wdat;
            #3;
            check("tap_gnt", bus.cfg_tap_gnt, 1);
            check("tap_WE", bus.tap_WE, tv[i].we);
            check("tap_A", bus.tap_A, tv[i].a);
            tick();
            bus.cfg_tap_req = 0;
            if (!tv[i].wr) begin
                #3;
                check("tap_readback", tap_do, tv[i].rd);
                tick();
            end
        end

        // zero length, then status read clears ap_done
        run(0, -1, 0, 0, 0, 0);
        bus.cfg_stat_rd = 1;
        tick();
        bus.cfg_stat_rd = 0;
        #3 check("stat_rd_clears_done", bus.ap_done, 0);
        tick();

        run(1, -1, 0, 0, 0, 0);
`ifdef FIR_SCHED_PERF_CNT_EN
        check("perf_cycles", bus.perf_cycles, 25);
`else
        check("perf_cycles_off", bus.perf_cycles, 0);
`endif
        run(600, -1, 0, 0, 1, 0);
        run(20, -1, 0, 1, 0, 0);
        run(5, 2, 0, 0, 0, 0);
        run(13, -1, 0, 0, 0, 1);
        for (int r = 0; r < 3; r++) run(int'($urandom_range(12, 60)), -1, 1, 0, r[0], 0);

        // reset in the middle of MAC
        bus.cfg_start = 1; bus.cfg_len = 3;
        tick();
        bus.cfg_start = 0; bus.ss_tvalid = 1; ss_tdata = 7;
        for (int i = 0; i < 40 && !bus.ss_tready; i++) tick();
        tick();
        bus.ss_tvalid = 0;
        tick(); tick();
        #2;
        check("pre_rst_mac_en", bus.mac_en, 1);
        axis_rst = 1;
        #1;
        check("midrun_rst_outputs", active_bits(), 0);
        check("midrun_rst_idle", bus.ap_idle, 1);
        #2 axis_rst = 0;
        tick();
        run(3, -1, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_sched.md
Name: fir_sched

Overview:
- Sequencer and resource arbiter for the 11-tap FIR datapath.
- Owns the ap_start/ap_done/ap_idle protocol and shares the tap RAM between AXI-lite configuration access and the compute engine.
- Generates the circular data-RAM addressing, the AXI-Stream ss/sm handshakes and the MAC enables.
- Sits between the AXI-lite register decode, the two bram11 instances and the multiply-accumulate datapath inside fir.

Parameters:
- pADDR_WIDTH, 12, RAM address width; byte address = 4*word index.
- pDATA_WIDTH, 32, data width; sets the width of cfg_len and perf_cycles.
- Tape_Num, 11, number of taps; also the data-RAM depth.

Ports:
- axis_clk  in  1  sole clock.
- axis_rst  in  1  reset, asynchronous, active-high.
- cfg_start  in  1  one-cycle pulse on AXI-lite write of 1 to 0x00 bit0.
- cfg_len  in  pDATA_WIDTH  sample count (register 0x10); sampled on accepted start.
- cfg_stat_rd  in  1  pulse when 0x00 is read.
- cfg_tap_req  in  1  AXI-lite requests tap RAM.
- cfg_tap_wr  in  1  1 = write, 0 = read; valid with cfg_tap_req.
- cfg_tap_idx  in  4  tap word index 0..Tape_Num-1.
- cfg_tap_gnt  out  1  tap RAM granted to AXI-lite this cycle.
- ss_tvalid  in  1  input stream valid.
- ss_tlast  in  1  input stream last.
- ss_tready  out  1  input accepted.
- sm_tready  in  1  output stream ready.
- sm_tvalid  out  1  output stream valid.
- sm_tlast  out  1  final output sample.
- tap_EN  out  1  tap RAM enable.
- tap_WE  out  4  tap RAM byte write enables.
- tap_A  out  pADDR_WIDTH  tap RAM byte address.
- data_EN  out  1  data RAM enable.
- data_WE  out  4  data RAM byte write enables.
- data_A  out  pADDR_WIDTH  data RAM byte address.
- data_sel_zero  out  1  datapath drives data_Di = 0 (clear) instead of ss_tdata.
- mac_clr  out  1  clear accumulator.
- mac_en  out  1  accumulate tap_Do*data_Do.
- ap_start  out  1  status bit0.
- ap_done  out  1  status bit1.
- ap_idle  out  1  status bit2.
- err_tlast  out  1  sticky: ss_tlast disagreed with the sample count.
- perf_cycles  out  pDATA_WIDTH  busy-cycle count (optional feature).

Behaviour:
- Reset: state IDLE. ap_idle=1; every other output 0; pointers and counters 0. Asserting axis_rst mid-run aborts at once to IDLE and RAM contents are not cleared.
- RAM timing: bram11 read latency is 1 cycle; Do is valid the cycle after EN with WE=0.
- IDLE: cfg_tap_gnt=cfg_tap_req. When granted: tap_EN=1, tap_A=4*cfg_tap_idx, tap_WE=4'hF if cfg_tap_wr. cfg_start → INIT; latch cfg_len, ap_start=1, ap_idle=0, ap_done=0.
- INIT: Tape_Num cycles writing zero to data words 0..10 (data_WE=F, data_sel_zero=1). Then wptr=0 and → WAIT_IN, or → DONE if latched length = 0.
- WAIT_IN: ss_tready=1. On handshake:
  - write sample to word wptr;
  - mac_clr=1; ap_start clears on the first sample;
  - sample counter +1;
  - err_tlast sets if ss_tlast != (counter == len-1).
  - → MAC.
- MAC: Tape_Num cycles, k=0..10. tap_A=4*k; data_A=4*((wptr-k) mod Tape_Num). mac_en asserted for k+1 (one-cycle lag), including one drain cycle after k=10. Then → OUT. Sample-to-sm_tvalid latency = Tape_Num+2 cycles after the ss handshake.
- OUT: sm_tvalid=1 and held until sm_tready. sm_tlast=1 when this is sample len-1. On handshake wptr = (wptr+1) mod Tape_Num, wrapping 10→0. Then → DONE if last, else WAIT_IN.
- DONE: ap_done=1, ap_idle=1; return to IDLE the next cycle. ap_done is held through IDLE until cfg_stat_rd or the next accepted cfg_start.
- Tap access while busy: only IDLE/DONE grant tap access; in all other states cfg_tap_gnt=0 and the requester stalls.
- cfg_start while busy: ignored.
- cfg_start and cfg_stat_rd in the same cycle: start wins; ap_done=0.
- Error flag: err_tlast clears on accepted start.
- Output marking: an ss_tlast received early does not shorten the run; cfg_len is authoritative.

Optional Feature:
- Macro: FIR_SCHED_PERF_CNT_EN.
- Defined: perf_cycles clears on accepted start and increments every cycle not in IDLE/DONE. It saturates at all-ones and holds after done.
- Undefined: perf_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Tap programming: write taps {0,-10,-9,23,56,63,56,23,-9,-10,0} in IDLE, read them back → cfg_tap_gnt same cycle as req; tap_WE=F on writes; tap_A=0x00..0x28.
- Normal run: len=600, stream triangular samples with sm_tready=1 → 600 outputs; sm_tlast only on #599; ap_done=1, ap_idle=1; err_tlast=0.
- Tap request while busy: cfg_tap_req during MAC → cfg_tap_gnt=0 until DONE. Also check for sample n=12: in MAC k=3, data_A=4*((0-3) mod 11)=0x20.
- Backpressure: sm_tready low 5 cycles in OUT → sm_tvalid held and ss_tready=0 throughout; no data lost.
- Edge cases:
  - len=0 → INIT, then DONE; ap_done=1 with no stream traffic.
  - ss_tlast on sample 3 of len=5 → err_tlast=1 and run still ends after 5 outputs.
  - axis_rst mid-MAC → all outputs at reset values within the same cycle.
- Optional feature (FIR_SCHED_PERF_CNT_EN): len=1 with immediate ready → perf_cycles = 11 INIT + 1 WAIT_IN + 12 MAC + 1 OUT = 25.
